// File: rtl/pit_channel_scheduler_if.sv
// IPIF slave bus bundle for the PIT channel scheduler.
// master drives CEs/data/BEs; slave returns read data, acks and error.
interface pit_channel_scheduler_if;
  logic [31:0] Bus2IP_Data;
  logic [3:0]  Bus2IP_BE;
  logic [3:0]  Bus2IP_RdCE;
  logic [3:0]  Bus2IP_WrCE;
  logic [31:0] IP2Bus_Data;
  logic        IP2Bus_RdAck;
  logic        IP2Bus_WrAck;
  logic        IP2Bus_Error;

  modport master (
    output Bus2IP_Data, Bus2IP_BE,
    output Bus2IP_RdCE, Bus2IP_WrCE,
    input  IP2Bus_Data, IP2Bus_RdAck,
    input  IP2Bus_WrAck, IP2Bus_Error
  );

  modport slave (
    input  Bus2IP_Data, Bus2IP_BE,
    input  Bus2IP_RdCE, Bus2IP_WrCE,
    output IP2Bus_Data, IP2Bus_RdAck,
    output IP2Bus_WrAck, IP2Bus_Error
  );
endinterface

// File: rtl/pit_channel_scheduler.sv
// Shares one PIT tick among N_CH countdown channels; pend flags are masked
// and ORed onto IP_Interupt. Ports: Bus2IP_Clk, Bus2IP_Reset (sync, high),
// pit_tick pulse, bus (IPIF slave: R0 CTRL, R1 STAT, R2 SEL, R3 CNT),
// IP_Interupt level output. Define PIT_SCHED_OVERRUN_EN to build overrun flags.
module pit_channel_scheduler #(
  parameter int N_CH    = 4,
  parameter int COUNT_W = 16
) (
  input  logic Bus2IP_Clk,
  input  logic Bus2IP_Reset,
  input  logic pit_tick,
  pit_channel_scheduler_if.slave bus,
  output logic IP_Interupt
);

  localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [N_CH-1:0]    en_q, per_q, msk_q, pend_q, ovr_q;
  logic [N_CH-1:0]    en_nx, per_nx, msk_nx, pend_nx, ovr_nx;
  logic [N_CH-1:0]    expire;
  logic [2:0]         sel_q, sel_nx;
  logic [COUNT_W-1:0] rel_q [N_CH];
  logic [COUNT_W-1:0] cnt_q [N_CH];
  logic [COUNT_W-1:0] rel_nx [N_CH];
  logic [COUNT_W-1:0] cnt_nx [N_CH];
  logic [COUNT_W-1:0] cnt_wdata;
  logic [SEL_W-1:0]   sel_idx;
  logic [31:0]        wmask, merged;
  logic [2:0]         lowest;
  logic               wr_ctrl, wr_stat, wr_sel, wr_cnt;

  assign wr_ctrl = bus.Bus2IP_WrCE[0];
  assign wr_stat = bus.Bus2IP_WrCE[1];
  assign wr_sel  = bus.Bus2IP_WrCE[2];
  assign wr_cnt  = bus.Bus2IP_WrCE[3];
  assign sel_idx = sel_q[SEL_W-1:0];

  assign wmask = {{8{bus.Bus2IP_BE[3]}}, {8{bus.Bus2IP_BE[2]}},
                  {8{bus.Bus2IP_BE[1]}}, {8{bus.Bus2IP_BE[0]}}};

  // Unenabled bytes of a CNT write keep the current reload bits.
  assign merged = (bus.Bus2IP_Data & wmask)
                | (32'(rel_q[sel_idx]) & ~wmask);
  assign cnt_wdata = merged[COUNT_W-1:0];

  always_comb begin
    expire = '0;
    for (int c = 0; c < N_CH; c++) begin
      logic hit, live;
      hit  = wr_cnt && (sel_idx == SEL_W'(c));
      // A CNT write to this channel swallows a coincident tick.
      live = pit_tick && en_q[c] && (rel_q[c] != '0) && !hit;
      rel_nx[c] = rel_q[c];
      cnt_nx[c] = cnt_q[c];
      if (live) begin
        if (cnt_q[c] == '0) begin
          cnt_nx[c] = rel_q[c];
        end else if (cnt_q[c] == COUNT_W'(1)) begin
          expire[c] = 1'b1;
          cnt_nx[c] = per_q[c] ? rel_q[c] : '0;
        end else begin
          cnt_nx[c] = cnt_q[c] - COUNT_W'(1);
        end
      end
      if (hit) begin
        rel_nx[c] = cnt_wdata;
        cnt_nx[c] = cnt_wdata;
      end
    end
  end

  always_comb begin
    en_nx  = en_q;
    per_nx = per_q;
    msk_nx = msk_q;
    pend_nx = pend_q;
    ovr_nx = '0;
    sel_nx = sel_q;
    if (wr_ctrl && bus.Bus2IP_BE[0]) en_nx  = bus.Bus2IP_Data[0 +: N_CH];
    if (wr_ctrl && bus.Bus2IP_BE[1]) per_nx = bus.Bus2IP_Data[8 +: N_CH];
    if (wr_ctrl && bus.Bus2IP_BE[2]) msk_nx = bus.Bus2IP_Data[16 +: N_CH];
    // One-shot expiry clears enable even against a coincident CTRL write.
    en_nx = en_nx & ~(expire & ~per_q);
    if (wr_stat && bus.Bus2IP_BE[0])
      pend_nx = pend_q & ~bus.Bus2IP_Data[0 +: N_CH];
    pend_nx = pend_nx | expire;
`ifdef PIT_SCHED_OVERRUN_EN
    ovr_nx = ovr_q;
    if (wr_stat && bus.Bus2IP_BE[2])
      ovr_nx = ovr_q & ~bus.Bus2IP_Data[16 +: N_CH];
    ovr_nx = ovr_nx | (expire & pend_q);
`endif
    if (wr_sel && bus.Bus2IP_BE[0]
        && (32'(bus.Bus2IP_Data[2:0]) < N_CH))
      sel_nx = bus.Bus2IP_Data[2:0];
  end

  always_ff @(posedge Bus2IP_Clk) begin
    if (Bus2IP_Reset) begin
      en_q   <= '0;
      per_q  <= '0;
      msk_q  <= '0;
      pend_q <= '0;
      ovr_q  <= '0;
      sel_q  <= '0;
      for (int c = 0; c < N_CH; c++) begin
        rel_q[c] <= '0;
        cnt_q[c] <= '0;
      end
    end else begin
      en_q   <= en_nx;
      per_q  <= per_nx;
      msk_q  <= msk_nx;
      pend_q <= pend_nx;
      ovr_q  <= ovr_nx;
      sel_q  <= sel_nx;
      for (int c = 0; c < N_CH; c++) begin
        rel_q[c] <= rel_nx[c];
        cnt_q[c] <= cnt_nx[c];
      end
    end
  end

  always_comb begin
    lowest = '0;
    for (int c = N_CH - 1; c >= 0; c--)
      if (pend_q[c]) lowest = 3'(c);
  end

  always_comb begin
    bus.IP2Bus_Data = '0;
    unique case (1'b1)
      bus.Bus2IP_RdCE[0]:
        bus.IP2Bus_Data = {8'h00, 8'(msk_q), 8'(per_q), 8'(en_q)};
      bus.Bus2IP_RdCE[1]:
        bus.IP2Bus_Data = {|pend_q, lowest, 4'h0,
                           8'(ovr_q), 8'h00, 8'(pend_q)};
      bus.Bus2IP_RdCE[2]:
        bus.IP2Bus_Data = {29'd0, sel_q};
      bus.Bus2IP_RdCE[3]:
        bus.IP2Bus_Data = 32'(cnt_q[sel_idx]);
      default:
        bus.IP2Bus_Data = '0;
    endcase
  end

  assign bus.IP2Bus_RdAck = |bus.Bus2IP_RdCE;
  assign bus.IP2Bus_WrAck = |bus.Bus2IP_WrCE;
  assign bus.IP2Bus_Error = 1'b0;
  assign IP_Interupt      = |(pend_q & msk_q);

endmodule

// File: tb/tb_pit_channel_scheduler.sv
// Randomized and directed bench for pit_channel_scheduler against a
// behavioural register/channel model.
module tb_pit_channel_scheduler;
  localparam int N_CH    = 4;
  localparam int COUNT_W = 16;
  localparam int NMASK   = (1 << N_CH) - 1;
  localparam longint CWM = (longint'(1) << COUNT_W) - 1;
`ifdef PIT_SCHED_OVERRUN_EN
  localparam bit OVR = 1'b1;
`else
  localparam bit OVR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, tick, irq;
  logic [31:0] q;

  pit_channel_scheduler_if bus();

  pit_channel_scheduler #(.N_CH(N_CH), .COUNT_W(COUNT_W)) dut (
    .Bus2IP_Clk  (clk),
    .Bus2IP_Reset(rst),
    .pit_tick    (tick),
    .bus         (bus),
    .IP_Interupt (irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int m_en, m_per, m_msk, m_pend, m_ovr, m_sel;
  longint m_rel [N_CH];
  longint m_cnt [N_CH];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void m_reset();
    m_en = 0; m_per = 0; m_msk = 0; m_pend = 0; m_ovr = 0; m_sel = 0;
    for (int c = 0; c < N_CH; c++) begin
      m_rel[c] = 0;
      m_cnt[c] = 0;
    end
  endfunction

  function automatic logic [31:0] m_read(input int r);
    logic [31:0] v;
    int lo;
    v = '0;
    case (r)
      0: v = 32'(m_en | (m_per << 8) | (m_msk << 16));
      1: begin
        lo = 0;
        for (int c = N_CH - 1; c >= 0; c--)
          if (m_pend[c]) lo = c;
        v = 32'(m_pend | (m_ovr << 16));
        v[31] = (m_pend != 0);
        v[30:28] = 3'(lo);
      end
      2: v = 32'(m_sel);
      default: v = 32'(m_cnt[m_sel]);
    endcase
    return v;
  endfunction

  function automatic void m_step(input int wr, input logic [31:0] d,
                                 input logic [3:0] be, input bit tk);
    int exp_m, oneshot, pend_old;
    logic [31:0] mg;
    exp_m = 0; oneshot = 0; pend_old = m_pend;
    for (int c = 0; c < N_CH; c++) begin
      bit hit;
      hit = (wr == 3) && (c == m_sel);
      if (tk && m_en[c] && m_rel[c] != 0 && !hit) begin
        if (m_cnt[c] == 0) m_cnt[c] = m_rel[c];
        else if (m_cnt[c] == 1) begin
          exp_m |= 1 << c;
          if (m_per[c]) m_cnt[c] = m_rel[c];
          else begin
            m_cnt[c] = 0;
            oneshot |= 1 << c;
          end
        end else m_cnt[c] = m_cnt[c] - 1;
      end
    end
    case (wr)
      0: begin
        if (be[0]) m_en  = int'(d[7:0]) & NMASK;
        if (be[1]) m_per = int'(d[15:8]) & NMASK;
        if (be[2]) m_msk = int'(d[23:16]) & NMASK;
      end
      1: begin
        if (be[0]) m_pend &= ~int'(d[7:0]);
        if (OVR && be[2]) m_ovr &= ~int'(d[23:16]);
      end
      2: if (be[0] && d[2:0] < N_CH) m_sel = int'(d[2:0]);
      3: begin
        mg = m_rel[m_sel][31:0];
        for (int b = 0; b < 4; b++)
          if (be[b]) mg[8*b +: 8] = d[8*b +: 8];
        m_rel[m_sel] = longint'(mg) & CWM;
        m_cnt[m_sel] = m_rel[m_sel];
      end
      default: ;
    endcase
    m_en &= ~oneshot;
    if (OVR) m_ovr |= exp_m & pend_old;
    m_pend |= exp_m;
  endfunction

  // Called just after a rising edge; returns read data sampled mid-cycle.
  task automatic cyc(input int rd, input int wr, input logic [31:0] d,
                     input logic [3:0] be, input bit tk, input bit r,
                     output logic [31:0] rq);
    bus.Bus2IP_RdCE = (rd >= 0) ? 4'(1 << rd) : 4'h0;
    bus.Bus2IP_WrCE = (wr >= 0) ? 4'(1 << wr) : 4'h0;
    bus.Bus2IP_Data = d;
    bus.Bus2IP_BE   = be;
    tick = tk;
    rst  = r;
    @(negedge clk);
    rq = bus.IP2Bus_Data;
    check("irq", 32'(irq), 32'((m_pend & m_msk) != 0));
    check("rdack", 32'(bus.IP2Bus_RdAck), 32'(rd >= 0));
    check("wrack", 32'(bus.IP2Bus_WrAck), 32'(wr >= 0));
    check("error", 32'(bus.IP2Bus_Error), 32'd0);
    if (rd >= 0) check($sformatf("rd_r%0d", rd), rq, m_read(rd));
    else check("rd_idle", rq, 32'd0);
    @(posedge clk);
    if (r) m_reset();
    else m_step(wr, d, be, tk);
    #1;
    bus.Bus2IP_RdCE = 4'h0;
    bus.Bus2IP_WrCE = 4'h0;
    tick = 1'b0;
    rst  = 1'b0;
  endtask

  task automatic wr_reg(input int r, input logic [31:0] d);
    logic [31:0] dummy;
    cyc(-1, r, d, 4'hF, 1'b0, 1'b0, dummy);
  endtask

  task automatic rd_reg(input int r, output logic [31:0] d);
    cyc(r, -1, 32'd0, 4'h0, 1'b0, 1'b0, d);
  endtask

  task automatic ticks(input int n);
    logic [31:0] dummy;
    for (int i = 0; i < n; i++) cyc(-1, -1, 32'd0, 4'h0, 1'b1, 1'b0, dummy);
  endtask

  task automatic do_reset(input int n);
    logic [31:0] dummy;
    for (int i = 0; i < n; i++) cyc(-1, -1, 32'd0, 4'h0, 1'b1, 1'b1, dummy);
  endtask

  initial begin
    logic [31:0] dummy;
    bus.Bus2IP_RdCE = 4'h0;
    bus.Bus2IP_WrCE = 4'h0;
    bus.Bus2IP_Data = 32'd0;
    bus.Bus2IP_BE   = 4'h0;
    tick = 1'b0;
    rst  = 1'b1;
    m_reset();
    @(posedge clk);
    #1;
    do_reset(2);
    for (int r = 0; r < 4; r++) begin
      rd_reg(r, q);
      check($sformatf("reset_r%0d", r), q, 32'd0);
    end
    check("reset_irq", 32'(irq), 32'd0);

    wr_reg(2, 32'd1);
    wr_reg(3, 32'd3);
    wr_reg(0, 32'h0000_0202);
    ticks(7);
    check("per_irq_masked", 32'(irq), 32'd0);
    rd_reg(1, q);
    check("per_stat", q, OVR ? 32'h9002_0002 : 32'h9000_0002);
    wr_reg(0, 32'h0002_0202);
    check("per_irq_unmasked", 32'(irq), 32'd1);

    do_reset(1);
    wr_reg(2, 32'd0);
    wr_reg(3, 32'd2);
    wr_reg(0, 32'h0001_0001);
    ticks(2);
    rd_reg(1, q);
    check("oneshot_stat", q, 32'h8000_0001);
    rd_reg(0, q);
    check("oneshot_ctrl", q, 32'h0001_0000);
    check("oneshot_irq", 32'(irq), 32'd1);
    wr_reg(1, 32'h1);
    check("w1c_irq", 32'(irq), 32'd0);

    do_reset(1);
    wr_reg(2, 32'd2);
    wr_reg(3, 32'd1);
    wr_reg(2, 32'd3);
    wr_reg(3, 32'd1);
    wr_reg(0, 32'h0000_000C);
    ticks(1);
    rd_reg(1, q);
    check("multi_stat", q, 32'hA000_000C);

    do_reset(1);
    wr_reg(2, 32'd0);
    wr_reg(3, 32'd5);
    wr_reg(0, 32'h1);
    cyc(-1, 3, 32'd7, 4'hF, 1'b1, 1'b0, dummy);
    rd_reg(3, q);
    check("cnt_wins", q, 32'd7);
    wr_reg(0, 32'h0101);
    wr_reg(3, 32'd1);
    ticks(1);
    cyc(-1, 1, 32'h1, 4'hF, 1'b1, 1'b0, dummy);
    rd_reg(1, q);
    check("set_wins", q, OVR ? 32'h8001_0001 : 32'h8000_0001);

    do_reset(1);
    wr_reg(3, 32'd1);
    wr_reg(0, 32'h0101);
    ticks(2);
    rd_reg(1, q);
    check("overrun_bit", 32'(q[16]), 32'(OVR));
    wr_reg(2, 32'd6);
    rd_reg(2, q);
    check("sel_ignored", q, 32'd0);

    do_reset(1);
    for (int i = 0; i < 3000; i++) begin
      int op, r;
      logic [31:0] d;
      logic [3:0] be;
      bit tk;
      op = $urandom % 10;
      r  = $urandom % 4;
      tk = ($urandom % 3) == 0;
      be = (($urandom % 4) == 0) ? 4'($urandom) : 4'hF;
      case (r)
        2: d = 32'($urandom_range(0, 7));
        3: d = (($urandom % 8) == 0) ? $urandom : 32'($urandom_range(0, 6));
        default: d = $urandom;
      endcase
      if (op <= 3) cyc(-1, -1, 32'd0, 4'h0, tk, 1'b0, dummy);
      else if (op <= 5) cyc(r, -1, 32'd0, 4'h0, tk, 1'b0, dummy);
      else if (op <= 8) cyc(-1, r, d, be, tk, 1'b0, dummy);
      else if (($urandom % 20) == 0) cyc(-1, -1, 32'd0, 4'h0, tk, 1'b1, dummy);
      else cyc(-1, -1, 32'd0, 4'h0, tk, 1'b0, dummy);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
